// File: rtl/nvic_nested.sv
// Nesting priority interrupt controller: latches level/edge sources, masks them with ENABLE,
// and presents the highest code that is strictly above the current in-service level.
module nvic_nested #(
    parameter int N_SRC  = 11,
    parameter int CODE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [1:0]        i_memAddr,
    input  logic [15:0]       i_memDataIn,
    input  logic              i_memWrEn,
    output logic [15:0]       o_memDataOut,
    input  logic [N_SRC-1:0]  i_irq,
    input  logic              i_intAck,
    output logic [CODE_W-1:0] o_intCode,
    output logic              o_intEn,
    output logic [CODE_W-1:0] o_isrLevel
);

    localparam logic [1:0] ADDR_ENABLE = 2'b00;
    localparam logic [1:0] ADDR_FLAGS  = 2'b01;
    localparam logic [1:0] ADDR_MODE   = 2'b10;
    localparam logic [1:0] ADDR_ISR    = 2'b11;

    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [N_SRC-1:0]  flags_q, flags_d;
    logic [N_SRC-1:0]  mode_q, mode_d;
    logic [N_SRC-1:0]  isr_q, isr_d;
    logic [N_SRC-1:0]  irq_prev_q;

    logic [N_SRC-1:0]  pend;
    logic [N_SRC-1:0]  wr_data;
    logic [N_SRC-1:0]  set_mask;
    logic [N_SRC-1:0]  w1c_mask;
    logic [N_SRC-1:0]  ack_mask;
    logic [N_SRC-1:0]  eoi_mask;
    logic [N_SRC-1:0]  rd_reg;
    logic [CODE_W-1:0] cand_code;
    logic [CODE_W-1:0] isr_level;
    logic [CODE_W-1:0] int_code;
    logic              ack_fire;
    logic              eoi;
    logic              unused_wdata;

    assign pend         = enable_q & flags_q;
    assign wr_data      = i_memDataIn[N_SRC:1];
    assign unused_wdata = ^i_memDataIn;

    always_comb begin
        cand_code = '0;
        isr_level = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (pend[k]) cand_code = CODE_W'(k + 1);
            if (isr_q[k]) isr_level = CODE_W'(k + 1);
        end
    end

    // Only a strictly higher code than the one in service may be presented.
    assign int_code   = (cand_code > isr_level) ? cand_code : '0;
    assign o_intCode  = int_code;
    assign o_intEn    = |int_code;
    assign o_isrLevel = isr_level;

    assign ack_fire = i_intAck & o_intEn;
    assign eoi      = i_memWrEn && (i_memAddr == ADDR_ISR);
    assign w1c_mask = (i_memWrEn && (i_memAddr == ADDR_FLAGS)) ? wr_data : '0;

    always_comb begin
        ack_mask = '0;
        eoi_mask = '0;
        for (int k = 0; k < N_SRC; k++) begin
            ack_mask[k] = ack_fire && (int_code == CODE_W'(k + 1));
            eoi_mask[k] = eoi && (isr_level == CODE_W'(k + 1));
        end
    end

    // Level sources set while high; edge sources only on a 0->1 sample.
    assign set_mask = i_irq & ~(mode_q & irq_prev_q);

    always_comb begin
        flags_d  = (flags_q & ~(w1c_mask | ack_mask)) | set_mask;
        isr_d    = (isr_q & ~eoi_mask) | ack_mask;
        enable_d = (i_memWrEn && (i_memAddr == ADDR_ENABLE)) ? wr_data : enable_q;
        mode_d   = (i_memWrEn && (i_memAddr == ADDR_MODE)) ? wr_data : mode_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            enable_q   <= '0;
            flags_q    <= '0;
            mode_q     <= '0;
            isr_q      <= '0;
            irq_prev_q <= '0;
        end else begin
            enable_q   <= enable_d;
            flags_q    <= flags_d;
            mode_q     <= mode_d;
            isr_q      <= isr_d;
            irq_prev_q <= i_irq;
        end
    end

    always_comb begin
        unique case (i_memAddr)
            ADDR_ENABLE: rd_reg = enable_q;
            ADDR_FLAGS:  rd_reg = flags_q;
            ADDR_MODE:   rd_reg = mode_q;
            default:     rd_reg = isr_q;
        endcase
    end

    always_comb begin
        o_memDataOut = '0;
        o_memDataOut[N_SRC:1] = rd_reg;
    end

endmodule
